// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and byte width shared by the uart_tx arbiter files
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte bus plus the uart_tx data/strobe/ready pair
//   req_valid/req_data/req_last : requester i offers byte [8i+7:8i], last marks packet end
//   req_ack                     : one-hot pulse, byte captured
//   tx_data/tx_strobe/tx_ready  : uart_tx transmitter handshake
//   master = requesters and transmitter side, slave = arbiter side
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    import uart_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [BYTE_W*NREQ-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ack;
    logic [BYTE_W-1:0]      tx_data;
    logic                   tx_strobe;
    logic                   tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ack, tx_data, tx_strobe
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ack, tx_data, tx_strobe
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   mask  : candidate requesters
//   ptr   : last winner; search starts at ptr+1 and wraps, visiting ptr itself last
//   idx   : first set mask bit in that order
//   found : any mask bit set
module rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] j;

    // Walk the search order backwards so the nearest candidate after ptr is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (mask[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NREQ requesters, round-robin with packet locking
//   mclk, reset_n : clock, asynchronous active-low reset
//   bus           : requester byte bus and uart_tx handshake (slave side)
//   grant_id      : last/current owner
//   locked        : packet lock held by grant_id
//   busy          : a byte is in flight through the strobe / ready-low / ready-high handshake
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int LOCK_TIMEOUT = 65535,
    parameter  int WAIT_LOW_MAX = 3,
    localparam int GW           = $clog2(NREQ),
    localparam int LW           = $clog2(LOCK_TIMEOUT + 1),
    localparam int WW           = $clog2(WAIT_LOW_MAX + 1)
) (
    input  logic                mclk,
    input  logic                reset_n,
    uart_tx_arbiter_if.slave    bus,
    output logic [GW-1:0]       grant_id,
    output logic                locked,
    output logic                busy
);

    state_t            state;
    logic [LW-1:0]     lock_cnt;
    logic [WW-1:0]     wl_cnt;
    logic [NREQ-1:0]   mask;
    logic [GW-1:0]     pick;
    logic              found;
    logic [BYTE_W-1:0] sel_data;

    // While locked only the owner competes; the wrap search then lands on it.
    assign mask = locked ? (bus.req_valid & (NREQ'(1) << grant_id)) : bus.req_valid;
    assign busy = state != IDLE;

    rr_pick #(.N(NREQ)) u_pick (
        .mask  (mask),
        .ptr   (grant_id),
        .idx   (pick),
        .found (found)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick == GW'(i)) sel_data = bus.req_data[i*BYTE_W +: BYTE_W];
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bus.tx_strobe <= 1'b0;
            bus.tx_data   <= '0;
            bus.req_ack   <= '0;
            grant_id      <= GW'(NREQ - 1);
            locked        <= 1'b0;
            lock_cnt      <= '0;
            wl_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tx_ready && found) begin
                        bus.tx_data   <= sel_data;
                        bus.tx_strobe <= 1'b1;
                        bus.req_ack   <= NREQ'(1) << pick;
                        grant_id      <= pick;
                        locked        <= !bus.req_last[pick];
                        lock_cnt      <= '0;
                        state         <= WAIT_LOW;
                    end else if (locked && !bus.req_valid[grant_id]) begin
                        // Owner went quiet: give up the lock after LOCK_TIMEOUT idle cycles.
                        if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    bus.tx_strobe <= 1'b0;
                    bus.req_ack   <= '0;
                    // A transmitter that never drops ready must not stall the arbiter.
                    if (!bus.tx_ready || wl_cnt == WW'(WAIT_LOW_MAX - 1)) begin
                        wl_cnt <= '0;
                        state  <= WAIT_HIGH;
                    end else begin
                        wl_cnt <= wl_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (bus.tx_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with requester queues and a uart_tx ready model
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ  = 4;
    localparam int FRAME = 4;

    typedef struct packed {
        logic       lk;
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    logic       mclk    = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] grant_id;
    logic       locked;
    logic       busy;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .LOCK_TIMEOUT (16),
        .WAIT_LOW_MAX (3)
    ) dut (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .bus      (bus),
        .grant_id (grant_id),
        .locked   (locked),
        .busy     (busy)
    );

    always #5 mclk = ~mclk;

    exp_t       sb[$];
    int         st_q[$];
    int         checks  = 0;
    int         fails   = 0;
    int         cyc     = 0;
    int         strobes = 0;
    logic [8:0] rmem [NREQ][16];
    int         wr [NREQ] = '{default: 0};
    int         rd [NREQ] = '{default: 0};
    logic       force_mode  = 1'b0;
    logic       force_val   = 1'b1;
    logic       model_ready = 1'b1;
    int         fcnt        = 0;

    // Requester queues advance on ack; uart_tx model drops ready for FRAME cycles after a strobe.
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NREQ; i++)
            if (bus.req_ack[i]) rd[i] <= rd[i] + 1;
        if (bus.tx_strobe) begin
            model_ready <= 1'b0;
            fcnt        <= FRAME;
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) model_ready <= 1'b1;
        end
    end

    assign bus.tx_ready = force_mode ? force_val : model_ready;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign bus.req_valid[g]       = rd[g] != wr[g];
        assign bus.req_data[8*g +: 8] = rmem[g][4'(rd[g])][7:0];
        assign bus.req_last[g]        = rmem[g][4'(rd[g])][8];
    end

    always @(negedge mclk) begin
        exp_t e;
        if (reset_n && bus.tx_strobe) begin
            strobes++;
            st_q.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got strobe data=%h ack=%b, required no strobe", bus.tx_data, bus.req_ack);
            end else begin
                e = sb.pop_front();
                if ({bus.tx_data, bus.req_ack, grant_id, locked} !== {e.d, 4'b1 << e.id, e.id, e.lk}) begin
                    fails++;
                    $display("FAIL sb_byte: got data=%h ack=%b gid=%0d lock=%b, required data=%h ack=%b gid=%0d lock=%b",
                             bus.tx_data, bus.req_ack, grant_id, locked, e.d, 4'b1 << e.id, e.id, e.lk);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic push_req(input int i, input logic [7:0] d, input logic last);
        rmem[2'(i)][4'(wr[i])] = {last, d};
        wr[i]++;
    endtask

    task automatic expect_byte(input int i, input logic [7:0] d, input logic lk);
        sb.push_back(exp_t'{lk, 2'(i), d});
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge mclk);
            ok = sb.size() == 0;
        end
    endtask

    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge mclk);
            ok = bus.tx_strobe;
        end
    endtask

    task automatic do_reset;
        reset_n    = 1'b0;
        force_mode = 1'b0;
        force_val  = 1'b1;
        for (int i = 0; i < NREQ; i++) wr[i] = rd[i];
        sb.delete();
        st_q.delete();
        cycles(6);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cycles(2);
        checks++;
        if ({bus.tx_data, bus.tx_strobe, bus.req_ack, grant_id, locked, busy} !== {8'h00, 1'b0, 4'b0, 2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: got data=%h stb=%b ack=%b gid=%0d lock=%b busy=%b, required 00 0 0000 3 0 0",
                     bus.tx_data, bus.tx_strobe, bus.req_ack, grant_id, locked, busy);
        end
        reset_n = 1'b1;
        cycles(3);
        checks++;
        if ({strobes, grant_id, busy} !== {32'd0, 2'd3, 1'b0}) begin
            fails++;
            $display("FAIL reset_idle: got strobes=%0d gid=%0d busy=%b, required 0 3 0", strobes, grant_id, busy);
        end
    endtask

    task automatic test_single;
        bit ok;
        int s0;
        do_reset();
        s0 = strobes;
        push_req(0, 8'h41, 1'b1);
        expect_byte(0, 8'h41, 1'b0);
        wait_strobe(20, ok);
        checks++;
        if (!ok || !busy) begin
            fails++;
            $display("FAIL single_strobe: got seen=%b busy=%b, required seen=1 busy=1", ok, busy);
        end
        cycles(3);
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy_hold: got busy=%b, required 1", busy);
        end
        cycles(10);
        checks++;
        if ({busy, strobes - s0, sb.size()} !== {1'b0, 32'd1, 32'd0}) begin
            fail_line_single(busy, strobes - s0);
        end
    endtask

    task automatic fail_line_single(input logic b, input int n);
        fails++;
        $display("FAIL single_done: got busy=%b strobes=%0d pending=%0d, required busy=0 strobes=1 pending=0", b, n, sb.size());
    endtask

    task automatic test_fairness;
        bit ok;
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NREQ; i++) begin
                push_req(i, 8'h30 + 8'(i), 1'b1);
                expect_byte(i, 8'h30 + 8'(i), 1'b0);
            end
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL fair_drain: got %0d bytes outstanding, required 0", sb.size());
        end
        for (int j = 1; j < st_q.size(); j++) begin
            checks++;
            if (st_q[j] - st_q[j-1] !== 7) begin
                fails++;
                $display("FAIL fair_spacing[%0d]: got %0d cycles, required 7", j, st_q[j] - st_q[j-1]);
            end
        end
    endtask

    task automatic test_lock;
        bit ok;
        do_reset();
        push_req(1, 8'h10, 1'b1);
        expect_byte(1, 8'h10, 1'b0);
        wait_drain(30, ok);
        push_req(0, 8'hA0, 1'b1);
        push_req(2, 8'hC0, 1'b0);
        push_req(2, 8'hC1, 1'b0);
        push_req(2, 8'hC2, 1'b1);
        expect_byte(2, 8'hC0, 1'b1);
        expect_byte(2, 8'hC1, 1'b1);
        expect_byte(2, 8'hC2, 1'b0);
        expect_byte(0, 8'hA0, 1'b0);
        wait_drain(100, ok);
        checks++;
        if (!ok || st_q.size() != 5) begin
            fails++;
            $display("FAIL lock_drain: got %0d outstanding %0d strobes, required 0 outstanding 5 strobes", sb.size(), st_q.size());
        end
        for (int j = 1; j < st_q.size(); j++) begin
            checks++;
            if (st_q[j] - st_q[j-1] !== 7) begin
                fails++;
                $display("FAIL lock_spacing[%0d]: got %0d cycles, required 7", j, st_q[j] - st_q[j-1]);
            end
        end
    endtask

    task automatic test_lock_timeout;
        bit ok;
        do_reset();
        push_req(1, 8'h5A, 1'b0);
        push_req(3, 8'h3C, 1'b1);
        expect_byte(1, 8'h5A, 1'b1);
        expect_byte(3, 8'h3C, 1'b0);
        wait_drain(100, ok);
        checks++;
        if (!ok || st_q.size() != 2) begin
            fails++;
            $display("FAIL timeout_drain: got %0d outstanding %0d strobes, required 0 outstanding 2 strobes", sb.size(), st_q.size());
        end else begin
            checks++;
            if (st_q[1] - st_q[0] !== 23) begin
                fails++;
                $display("FAIL timeout_spacing: got %0d cycles, required 23", st_q[1] - st_q[0]);
            end
        end
    endtask

    task automatic test_busy_tx;
        bit ok;
        int s0;
        do_reset();
        force_mode = 1'b1;
        force_val  = 1'b0;
        s0 = strobes;
        push_req(0, 8'h61, 1'b1);
        push_req(0, 8'h62, 1'b1);
        expect_byte(0, 8'h61, 1'b0);
        expect_byte(0, 8'h62, 1'b0);
        cycles(10);
        checks++;
        if ({strobes - s0, busy} !== {32'd0, 1'b0}) begin
            fails++;
            $display("FAIL busy_hold_pending: got strobes=%0d busy=%b, required 0 0", strobes - s0, busy);
        end
        force_val = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge mclk);
            ok = strobes - s0 >= 2;
        end
        force_val = 1'b0;
        push_req(0, 8'h63, 1'b1);
        expect_byte(0, 8'h63, 1'b0);
        checks++;
        if (!ok || st_q.size() < 2) begin
            fails++;
            $display("FAIL stuck_ready_strobes: got %0d strobes, required 2", strobes - s0);
        end else begin
            checks++;
            if (st_q[1] - st_q[0] !== 5) begin
                fails++;
                $display("FAIL stuck_ready_spacing: got %0d cycles, required 5", st_q[1] - st_q[0]);
            end
        end
        cycles(10);
        checks++;
        if ({strobes - s0, busy} !== {32'd2, 1'b1}) begin
            fails++;
            $display("FAIL wait_high_hold: got strobes=%0d busy=%b, required 2 1", strobes - s0, busy);
        end
        force_val = 1'b1;
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_high_release: got %0d outstanding, required 0", sb.size());
        end
        cycles(8);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int s0;
        do_reset();
        push_req(2, 8'h55, 1'b0);
        expect_byte(2, 8'h55, 1'b1);
        wait_strobe(20, ok);
        cycles(3);
        checks++;
        if ({ok, busy, locked, grant_id} !== {1'b1, 1'b1, 1'b1, 2'd2}) begin
            fails++;
            $display("FAIL pre_reset: got seen=%b busy=%b lock=%b gid=%0d, required 1 1 1 2", ok, busy, locked, grant_id);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_data, bus.tx_strobe, bus.req_ack, grant_id, locked, busy} !== {8'h00, 1'b0, 4'b0, 2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: got data=%h stb=%b ack=%b gid=%0d lock=%b busy=%b, required 00 0 0000 3 0 0",
                     bus.tx_data, bus.tx_strobe, bus.req_ack, grant_id, locked, busy);
        end
        s0 = strobes;
        push_req(2, 8'h22, 1'b1);
        push_req(0, 8'h11, 1'b1);
        expect_byte(0, 8'h11, 1'b0);
        expect_byte(2, 8'h22, 1'b0);
        cycles(5);
        checks++;
        if (strobes !== s0) begin
            fails++;
            $display("FAIL reset_no_strobe: got %0d strobes, required 0", strobes - s0);
        end
        reset_n = 1'b1;
        wait_drain(60, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL post_reset_drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_lock_timeout();
        test_busy_tx();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
